// File: rtl/ram18_port_arbiter.sv
// Two-requester arbiter in front of a single 1Kx18 single-port block RAM
// that has a registered read.
// Either round-robin or fixed-priority (A first) arbitration is used.
// A clear engine can write CLR_VALUE to every word. While it runs, requests stall.
//
// state | meaning
// IDLE  | arbitrating between requesters A and B, at most one access per cycle
// CLEAR | writing CLR_VALUE to address clr_cnt, one word per cycle, 1024 cycles
module ram18_port_arbiter #(
    parameter logic [17:0] CLR_VALUE      = 18'h0,
    parameter int          FIXED_PRIORITY = 0
) (
    input  logic        CLK,
    input  logic        RST_N,

    input  logic        REQ_A,
    input  logic        WE_A,
    input  logic [9:0]  ADDR_A,
    input  logic [15:0] DI_A,
    input  logic [1:0]  DIP_A,
    output logic        GNT_A,
    output logic        RVALID_A,
    output logic [15:0] RDATA_A,
    output logic [1:0]  RDATAP_A,

    input  logic        REQ_B,
    input  logic        WE_B,
    input  logic [9:0]  ADDR_B,
    input  logic [15:0] DI_B,
    input  logic [1:0]  DIP_B,
    output logic        GNT_B,
    output logic        RVALID_B,
    output logic [15:0] RDATA_B,
    output logic [1:0]  RDATAP_B,

    input  logic        CLR_START,
    output logic        CLR_BUSY,
    output logic        CLR_DONE,

    output logic        RAM_EN,
    output logic        RAM_WE,
    output logic        RAM_SSR,
    output logic [9:0]  RAM_ADDR,
    output logic [15:0] RAM_DI,
    output logic [1:0]  RAM_DIP,
    input  logic [15:0] RAM_DO,
    input  logic [1:0]  RAM_DOP
);

    localparam bit FIXED = (FIXED_PRIORITY != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [9:0]  clr_cnt, clr_cnt_nxt;
    logic        last_b, last_b_nxt;     // 1: B was granted most recently
    logic        clr_done_q, clr_done_nxt;
    logic        rvalid_a_q, rvalid_b_q;
    logic        gnt_a, gnt_b;
    logic        a_wins;

    // Grant decision.
    // RST_N also gates the grants, so nothing is issued while reset is held.
    always_comb begin
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        a_wins = FIXED ? 1'b1 : last_b;
        if (RST_N && (state == IDLE)) begin
            if (REQ_A && REQ_B) begin
                gnt_a = a_wins;
                gnt_b = !a_wins;
            end else begin
                gnt_a = REQ_A;
                gnt_b = REQ_B;
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, RAM-side drive and bookkeeping next values
    always_comb begin
        state_nxt    = state;
        clr_cnt_nxt  = clr_cnt;
        last_b_nxt   = last_b;
        clr_done_nxt = 1'b0;
        RAM_EN       = 1'b0;
        RAM_WE       = 1'b0;
        RAM_ADDR     = 10'h0;
        RAM_DI       = 16'h0;
        RAM_DIP      = 2'b00;
        case (state)
            IDLE: begin
                if (gnt_a) begin
                    RAM_EN     = 1'b1;
                    RAM_WE     = WE_A;
                    RAM_ADDR   = ADDR_A;
                    RAM_DI     = DI_A;
                    RAM_DIP    = DIP_A;
                    last_b_nxt = 1'b0;
                end else if (gnt_b) begin
                    RAM_EN     = 1'b1;
                    RAM_WE     = WE_B;
                    RAM_ADDR   = ADDR_B;
                    RAM_DI     = DI_B;
                    RAM_DIP    = DIP_B;
                    last_b_nxt = 1'b1;
                end
                // The grant above still completes; the clear begins after the edge.
                if (CLR_START) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = 10'h0;
                end
            end
            CLEAR: begin
                RAM_EN              = 1'b1;
                RAM_WE              = 1'b1;
                RAM_ADDR            = clr_cnt;
                {RAM_DIP, RAM_DI}   = CLR_VALUE;
                clr_cnt_nxt         = clr_cnt + 10'd1;
                if (clr_cnt == 10'h3FF) begin
                    state_nxt    = IDLE;
                    clr_done_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Clear counter, round-robin pointer and done pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clr_cnt    <= 10'h0;
            last_b     <= 1'b1;
            clr_done_q <= 1'b0;
        end else begin
            clr_cnt    <= clr_cnt_nxt;
            last_b     <= last_b_nxt;
            clr_done_q <= clr_done_nxt;
        end
    end

    // Read-valid pulses: the RAM data shows up one cycle after a granted read
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rvalid_a_q <= gnt_a && !WE_A;
            rvalid_b_q <= gnt_b && !WE_B;
        end
    end

    assign GNT_A    = gnt_a;
    assign GNT_B    = gnt_b;
    assign RVALID_A = rvalid_a_q;
    assign RVALID_B = rvalid_b_q;
    assign RDATA_A  = RAM_DO;
    assign RDATAP_A = RAM_DOP;
    assign RDATA_B  = RAM_DO;
    assign RDATAP_B = RAM_DOP;
    assign CLR_BUSY = (state == CLEAR);
    assign CLR_DONE = clr_done_q;
    assign RAM_SSR  = 1'b0;

endmodule

// File: tb/tb_ram18_port_arbiter.sv
// Directed bench for ram18_port_arbiter.
// u_rr runs in round-robin mode with a clear value of 18'h3ABCD.
// u_fx runs in fixed-priority mode.
// Each instance drives its own behavioural 1Kx18 RAM with a registered read.
module tb_ram18_port_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst_n;

    logic        req_a, we_a, req_b, we_b, clr_start;
    logic [9:0]  addr_a, addr_b;
    logic [15:0] di_a, di_b;
    logic [1:0]  dip_a, dip_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b, clr_busy, clr_done;
    logic [15:0] rdata_a, rdata_b;
    logic [1:0]  rdatap_a, rdatap_b;
    logic        ram_en, ram_we, ram_ssr;
    logic [9:0]  ram_addr;
    logic [15:0] ram_di, ram_do;
    logic [1:0]  ram_dip, ram_dop;

    logic        f_req_a, f_req_b;
    logic        f_gnt_a, f_gnt_b, f_rvalid_a, f_rvalid_b, f_clr_busy, f_clr_done;
    logic [15:0] f_rdata_a, f_rdata_b;
    logic [1:0]  f_rdatap_a, f_rdatap_b;
    logic        f_ram_en, f_ram_we, f_ram_ssr;
    logic [9:0]  f_ram_addr;
    logic [15:0] f_ram_di, f_ram_do;
    logic [1:0]  f_ram_dip, f_ram_dop;

    int checks = 0;
    int errors = 0;

    ram18_port_arbiter #(.CLR_VALUE(18'h3ABCD), .FIXED_PRIORITY(0)) u_rr (
        .CLK(CLK), .RST_N(rst_n),
        .REQ_A(req_a), .WE_A(we_a), .ADDR_A(addr_a), .DI_A(di_a), .DIP_A(dip_a),
        .GNT_A(gnt_a), .RVALID_A(rvalid_a), .RDATA_A(rdata_a), .RDATAP_A(rdatap_a),
        .REQ_B(req_b), .WE_B(we_b), .ADDR_B(addr_b), .DI_B(di_b), .DIP_B(dip_b),
        .GNT_B(gnt_b), .RVALID_B(rvalid_b), .RDATA_B(rdata_b), .RDATAP_B(rdatap_b),
        .CLR_START(clr_start), .CLR_BUSY(clr_busy), .CLR_DONE(clr_done),
        .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_SSR(ram_ssr), .RAM_ADDR(ram_addr),
        .RAM_DI(ram_di), .RAM_DIP(ram_dip), .RAM_DO(ram_do), .RAM_DOP(ram_dop)
    );

    ram18_port_arbiter #(.CLR_VALUE(18'h0), .FIXED_PRIORITY(1)) u_fx (
        .CLK(CLK), .RST_N(rst_n),
        .REQ_A(f_req_a), .WE_A(1'b0), .ADDR_A(10'h001), .DI_A(16'h0), .DIP_A(2'b00),
        .GNT_A(f_gnt_a), .RVALID_A(f_rvalid_a), .RDATA_A(f_rdata_a), .RDATAP_A(f_rdatap_a),
        .REQ_B(f_req_b), .WE_B(1'b0), .ADDR_B(10'h002), .DI_B(16'h0), .DIP_B(2'b00),
        .GNT_B(f_gnt_b), .RVALID_B(f_rvalid_b), .RDATA_B(f_rdata_b), .RDATAP_B(f_rdatap_b),
        .CLR_START(1'b0), .CLR_BUSY(f_clr_busy), .CLR_DONE(f_clr_done),
        .RAM_EN(f_ram_en), .RAM_WE(f_ram_we), .RAM_SSR(f_ram_ssr), .RAM_ADDR(f_ram_addr),
        .RAM_DI(f_ram_di), .RAM_DIP(f_ram_dip), .RAM_DO(f_ram_do), .RAM_DOP(f_ram_dop)
    );

    logic [17:0] mem0 [1024];
    logic [17:0] mem1 [1024];

    always @(posedge CLK) begin
        if (ram_en) begin
            if (ram_we) begin
                mem0[ram_addr]    <= {ram_dip, ram_di};
                {ram_dop, ram_do} <= {ram_dip, ram_di};
            end else begin
                {ram_dop, ram_do} <= mem0[ram_addr];
            end
        end
    end

    always @(posedge CLK) begin
        if (f_ram_en) begin
            if (f_ram_we) begin
                mem1[f_ram_addr]      <= {f_ram_dip, f_ram_di};
                {f_ram_dop, f_ram_do} <= {f_ram_dip, f_ram_di};
            end else begin
                {f_ram_dop, f_ram_do} <= mem1[f_ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_a(input logic [9:0] a, input logic [15:0] d, input logic [1:0] p);
        req_a = 1'b1; we_a = 1'b1; addr_a = a; di_a = d; dip_a = p;
        #1;
        chk("wr_gnt_a", {31'b0, gnt_a}, 32'd1);
        tick();
        req_a = 1'b0; we_a = 1'b0;
        #1;
    endtask

    task automatic rd_a(input string tag, input logic [9:0] a, input logic [15:0] d, input logic [1:0] p);
        req_a = 1'b1; we_a = 1'b0; addr_a = a;
        #1;
        chk({tag, "_gnt"}, {31'b0, gnt_a}, 32'd1);
        tick();
        req_a = 1'b0;
        #1;
        chk({tag, "_rvalid"}, {31'b0, rvalid_a}, 32'd1);
        chk({tag, "_rdata"}, {16'b0, rdata_a}, {16'b0, d});
        chk({tag, "_rdatap"}, {30'b0, rdatap_a}, {30'b0, p});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb, busy, bad_gnt, bad_addr, dones, n;

        rst_n = 1'b0;
        req_a = 0; we_a = 0; addr_a = 0; di_a = 0; dip_a = 0;
        req_b = 0; we_b = 0; addr_b = 0; di_b = 0; dip_b = 0;
        clr_start = 0; f_req_a = 0; f_req_b = 0;
        tick(); tick();

        // Requests while reset is held must be masked
        req_a = 1'b1; req_b = 1'b1;
        #1;
        chk("rst_gnt_a", {31'b0, gnt_a}, 0);
        chk("rst_gnt_b", {31'b0, gnt_b}, 0);
        chk("rst_ram_en", {31'b0, ram_en}, 0);
        chk("rst_ram_we", {31'b0, ram_we}, 0);
        chk("rst_rvalid", {30'b0, rvalid_a, rvalid_b}, 0);
        chk("rst_clr", {30'b0, clr_busy, clr_done}, 0);
        chk("rst_ssr", {30'b0, ram_ssr, f_ram_ssr}, 0);
        chk("rst_fx_clr", {30'b0, f_clr_busy, f_clr_done}, 0);
        req_a = 1'b0; req_b = 1'b0;
        rst_n = 1'b1;
        tick();

        // Single-requester write then read-back
        req_a = 1'b1; we_a = 1'b1; addr_a = 10'h005; di_a = 16'h1234; dip_a = 2'b01;
        #1;
        chk("w_gnt_a", {31'b0, gnt_a}, 1);
        chk("w_gnt_b", {31'b0, gnt_b}, 0);
        chk("w_ram_en", {31'b0, ram_en}, 1);
        chk("w_ram_we", {31'b0, ram_we}, 1);
        chk("w_ram_addr", {22'b0, ram_addr}, 32'h005);
        chk("w_ram_data", {14'b0, ram_dip, ram_di}, 32'h11234);
        tick();
        we_a = 1'b0;
        #1;
        chk("w_no_rvalid", {31'b0, rvalid_a}, 0);
        chk("r_gnt_a", {31'b0, gnt_a}, 1);
        chk("r_ram_we", {31'b0, ram_we}, 0);
        tick();
        req_a = 1'b0;
        #1;
        chk("r_rvalid_a", {31'b0, rvalid_a}, 1);
        chk("r_rvalid_b", {31'b0, rvalid_b}, 0);
        chk("r_rdata_a", {16'b0, rdata_a}, 32'h1234);
        chk("r_rdatap_a", {30'b0, rdatap_a}, 32'h1);
        tick();
        chk("r_rvalid_once", {31'b0, rvalid_a}, 0);
        chk("idle_ram_en", {31'b0, ram_en}, 0);

        // Round-robin contention right after reset: A,B,A,B
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0; addr_a = 10'h005; addr_b = 10'h005;
        na = 0; nb = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_gnt_a_%0d", i), {31'b0, gnt_a}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_gnt_b_%0d", i), {31'b0, gnt_b}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (rvalid_a) na++;
            if (rvalid_b) nb++;
            tick();
        end
        req_a = 1'b0; req_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (rvalid_a) na++;
            if (rvalid_b) nb++;
            tick();
        end
        chk("rr_rvalid_a_count", na, 2);
        chk("rr_rvalid_b_count", nb, 2);

        // Fixed priority: A wins 3 cycles, then B once A drops
        f_req_a = 1'b1; f_req_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("fx_gnt_a_%0d", i), {31'b0, f_gnt_a}, 1);
            chk($sformatf("fx_gnt_b_%0d", i), {31'b0, f_gnt_b}, 0);
            tick();
        end
        f_req_a = 1'b0;
        #1;
        chk("fx_gnt_b_4", {31'b0, f_gnt_b}, 1);
        chk("fx_gnt_a_4", {31'b0, f_gnt_a}, 0);
        chk("fx_rvalid_a", {31'b0, f_rvalid_a}, 1);
        tick();
        f_req_b = 1'b0;
        #1;
        chk("fx_rvalid_b", {31'b0, f_rvalid_b}, 1);

        // Read granted just before reset gives no RVALID
        req_a = 1'b1; we_a = 1'b0; addr_a = 10'h005;
        #1;
        chk("pre_rst_gnt", {31'b0, gnt_a}, 1);
        rst_n = 1'b0;
        #1;
        tick();
        chk("pre_rst_no_rvalid", {31'b0, rvalid_a}, 0);
        req_a = 1'b0;
        rst_n = 1'b1;
        tick();

        // Whole-RAM clear with B stalled behind it
        clr_start = 1'b1;
        #1;
        chk("clr_start_busy", {31'b0, clr_busy}, 0);
        tick();
        clr_start = 1'b0;
        req_b = 1'b1; we_b = 1'b0; addr_b = 10'h005;
        #1;
        chk("clr_first_we", {30'b0, ram_en, ram_we}, 32'h3);
        chk("clr_first_data", {14'b0, ram_dip, ram_di}, 32'h3ABCD);
        busy = 0; bad_gnt = 0; bad_addr = 0;
        while (clr_busy === 1'b1 && busy < 2000) begin
            if (gnt_b !== 1'b0 || gnt_a !== 1'b0) bad_gnt++;
            if (ram_addr !== busy[9:0]) bad_addr++;
            busy++;
            tick();
            #1;
        end
        chk("clr_len", busy, 1024);
        chk("clr_no_gnt", bad_gnt, 0);
        chk("clr_addr_seq", bad_addr, 0);
        chk("clr_done", {31'b0, clr_done}, 1);
        chk("clr_gnt_b_after", {31'b0, gnt_b}, 1);
        tick();
        req_b = 1'b0;
        #1;
        chk("clr_done_pulse", {31'b0, clr_done}, 0);
        chk("clr_rvalid_b", {31'b0, rvalid_b}, 1);
        chk("clr_rdata_b", {14'b0, rdatap_b, rdata_b}, 32'h3ABCD);
        rd_a("clr_rd_3ff", 10'h3FF, 16'hABCD, 2'b11);
        rd_a("clr_rd_000", 10'h000, 16'hABCD, 2'b11);

        // Reset mid-clear at clear cycle 100
        wr_a(10'd99, 16'h1111, 2'b00);
        wr_a(10'd500, 16'h5A5A, 2'b10);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        req_a = 1'b1; we_a = 1'b0; addr_a = 10'h007;
        #1;
        n = 0;
        while (ram_addr !== 10'd100 && n < 2000) begin
            n++;
            tick();
            #1;
        end
        chk("mid_reached_100", {22'b0, ram_addr}, 100);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", {31'b0, clr_busy}, 0);
        chk("mid_ram_en", {30'b0, ram_en, ram_we}, 0);
        chk("mid_gnt", {30'b0, gnt_a, gnt_b}, 0);
        chk("mid_rvalid", {30'b0, rvalid_a, rvalid_b}, 0);
        chk("mid_done", {31'b0, clr_done}, 0);
        tick(); tick();
        req_a = 1'b0;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (clr_done) dones++;
        end
        chk("mid_no_done", dones, 0);
        rd_a("mid_rd_99", 10'd99, 16'hABCD, 2'b11);
        rd_a("mid_rd_500", 10'd500, 16'h5A5A, 2'b10);

        // CLR_START during a clear is ignored
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        #1;
        busy = 0; dones = 0;
        while (clr_busy === 1'b1 && busy < 2000) begin
            clr_start = (busy == 500);
            if (clr_done) dones++;
            busy++;
            tick();
            #1;
        end
        clr_start = 1'b0;
        chk("rs_len", busy, 1024);
        for (int i = 0; i < 1100; i++) begin
            if (clr_done) dones++;
            tick();
        end
        chk("rs_done_count", dones, 1);
        chk("rs_idle", {31'b0, clr_busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
